// File: rtl/ldst_issue_ctrl.sv
// In-order issue controller for the load/store reservation station: tracks dispatch order
// and issues the oldest ready entry into a registered valid/ready stage. Optional LDST_ISSUE_PERF_EN adds perf counters.
module ldst_issue_ctrl #(
    parameter int ENT_NUM  = 4,
    parameter int ENT_SEL  = 2,
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int RRF_SEL  = 6
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                we_1_i,
    input  logic                we_2_i,
    input  logic [ENT_SEL-1:0]  write_addr_1_i,
    input  logic [ENT_SEL-1:0]  write_addr_2_i,
    input  logic [ENT_NUM-1:0]  ready_vector_i,
    input  logic                flush_i,
    output logic [ENT_SEL-1:0]  issue_addr_o,
    output logic                clear_busy_o,
    input  logic [DATA_LEN-1:0] src_op_1_i,
    input  logic [DATA_LEN-1:0] src_op_2_i,
    input  logic [DATA_LEN-1:0] imm_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [RRF_SEL-1:0]  rrf_tag_i,
    input  logic                dst_val_i,
    output logic                issue_valid_o,
    input  logic                issue_ready_i,
    output logic [DATA_LEN-1:0] out_src_op_1_o,
    output logic [DATA_LEN-1:0] out_src_op_2_o,
    output logic [DATA_LEN-1:0] out_imm_o,
    output logic [ADDR_LEN-1:0] out_pc_o,
    output logic [RRF_SEL-1:0]  out_rrf_tag_o,
    output logic                out_dst_val_o,
    output logic                overflow_o
`ifdef LDST_ISSUE_PERF_EN
    ,
    output logic [31:0]         perf_issued_o,
    output logic [31:0]         perf_stall_o
`endif
);

    logic [ENT_SEL-1:0] order_q [ENT_NUM];
    logic [ENT_SEL-1:0] head_q, head_d;
    logic [ENT_SEL-1:0] tail_q, tail_d;
    logic [ENT_SEL:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic [ENT_SEL-1:0] head_ent;
    logic               fire;
    logic               push_ok;
    logic [ENT_SEL+1:0] need;

    logic [DATA_LEN-1:0] src1_q, src2_q, imm_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic [RRF_SEL-1:0]  tag_q;
    logic                dst_q;

    assign head_ent = order_q[head_q];

    // Fire is also held off during reset so nothing leaves the station while it is being cleared.
    assign fire = (count_q != '0) && ready_vector_i[head_ent] && (!valid_q || issue_ready_i)
                  && !flush_i && !reset_i;

    // A same-cycle pop frees its slot before the push capacity test.
    assign need    = (ENT_SEL+2)'(count_q) - (ENT_SEL+2)'(fire)
                   + (ENT_SEL+2)'(we_1_i) + (ENT_SEL+2)'(we_2_i);
    assign push_ok = (need <= (ENT_SEL+2)'(ENT_NUM));

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            if (fire) begin
                head_d = head_q + ENT_SEL'(1);
            end
            if (push_ok) begin
                tail_d  = tail_q + ENT_SEL'(we_1_i) + ENT_SEL'(we_2_i);
                count_d = need[ENT_SEL:0];
            end else begin
                count_d    = count_q - (ENT_SEL+1)'(fire);
                overflow_d = 1'b1;
            end
            if (fire) begin
                valid_d = 1'b1;
            end else if (valid_q && issue_ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i && push_ok) begin
            if (we_1_i) begin
                order_q[tail_q] <= write_addr_1_i;
                if (we_2_i) begin
                    order_q[tail_q + ENT_SEL'(1)] <= write_addr_2_i;
                end
            end else if (we_2_i) begin
                order_q[tail_q] <= write_addr_2_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            src1_q <= '0;
            src2_q <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            tag_q  <= '0;
            dst_q  <= 1'b0;
        end else if (fire) begin
            src1_q <= src_op_1_i;
            src2_q <= src_op_2_i;
            imm_q  <= imm_i;
            pc_q   <= pc_i;
            tag_q  <= rrf_tag_i;
            dst_q  <= dst_val_i;
        end
    end

`ifdef LDST_ISSUE_PERF_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (fire) begin
                issued_q <= issued_q + 32'd1;
            end else if (count_q != '0) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_issued_o = issued_q;
    assign perf_stall_o  = stall_q;
`endif

    assign issue_addr_o   = (count_q != '0) ? head_ent : '0;
    assign clear_busy_o   = fire;
    assign issue_valid_o  = valid_q;
    assign out_src_op_1_o = src1_q;
    assign out_src_op_2_o = src2_q;
    assign out_imm_o      = imm_q;
    assign out_pc_o       = pc_q;
    assign out_rrf_tag_o  = tag_q;
    assign out_dst_val_o  = dst_q;
    assign overflow_o     = overflow_q;

endmodule

// File: doc/ldst_issue_ctrl.md
# ldst_issue_ctrl

- In-order issue controller on the read side of the load/store reservation station.
- Records the program order of entries as dispatch writes them, and issues the oldest entry once the station reports it ready.
- On issue, it pulses the station's busy-clear and captures the selected payload into a registered valid/ready stage feeding the address-generation/LSU pipe.
- Memory operations therefore leave the station strictly in dispatch order.

## Interface

Parameters:
- `ENT_NUM`, 4, reservation-station entries
- `ENT_SEL`, 2, entry index width (log2 `ENT_NUM`)
- `DATA_LEN`, 32, operand/immediate width
- `ADDR_LEN`, 32, PC width
- `RRF_SEL`, 6, RRF tag width

Ports:
- `clk_i`  in  1  clock; all state on rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `we_1_i`, `we_2_i`  in  1  dispatch writes slot 1 / slot 2 this cycle; slot 1 is older
- `write_addr_1_i`, `write_addr_2_i`  in  `ENT_SEL`  station entry written by slot 1 / slot 2
- `ready_vector_i`  in  `ENT_NUM`  per-entry operands-ready from the station
- `flush_i`  in  1  pipeline kill; discards all tracked order and the output stage
- `issue_addr_o`  out  `ENT_SEL`  entry selected for read (head of order queue); 0 when empty
- `clear_busy_o`  out  1  issue fire; station clears busy of `issue_addr_o`
- `src_op_1_i`, `src_op_2_i`, `imm_i`  in  `DATA_LEN`  payload of entry `issue_addr_o`
- `pc_i`  in  `ADDR_LEN`  payload PC
- `rrf_tag_i`  in  `RRF_SEL`  payload destination tag
- `dst_val_i`  in  1  payload writes-back flag
- `issue_valid_o`  out  1  output stage holds an operation
- `issue_ready_i`  in  1  downstream accepts this cycle
- `out_src_op_1_o`, `out_src_op_2_o`, `out_imm_o`, `out_pc_o`, `out_rrf_tag_o`, `out_dst_val_o`  out  as inputs  registered payload
- `overflow_o`  out  1  sticky: dispatch pushed beyond capacity

## Operation

Order queue:
- Circular buffer of `ENT_NUM` entry indices, with head pointer, tail pointer and count (`ENT_SEL+1` bits); pointers wrap modulo `ENT_NUM`.
- Push per cycle:
  - both writes valid → `write_addr_1_i` at tail, `write_addr_2_i` at tail+1, tail += 2.
  - exactly one write valid → that address at tail, tail += 1.
- Pop and push in the same cycle are legal; next count = count + pushes − pop.
- A pop frees its slot for the same-cycle push evaluation: pushes are allowed if count − pop + pushes ≤ `ENT_NUM`.
- If pushes would exceed capacity, all of that cycle's pushes are dropped and `overflow_o` is set until reset.

Issue fire:
- `clear_busy_o` is combinational: count ≠ 0 AND `ready_vector_i[head]` AND (!`issue_valid_o` OR `issue_ready_i`) AND !`flush_i`.
- On fire: pop the head, load the output stage from the payload inputs, set `issue_valid_o`.
- When `issue_valid_o` && `issue_ready_i` and no fire: clear `issue_valid_o`.
- The output payload is held stable while `issue_valid_o` && !`issue_ready_i`.
- A non-ready head blocks younger ready entries; there is no bypass.

Flush:
- Clears count, head, tail and `issue_valid_o` next cycle.
- Overrides pushes and fire in the same cycle.
- `overflow_o` is unaffected.

## Timing

- Reset values: all outputs 0; queue empty; `overflow_o` = 0.
- An entry pushed in cycle N can fire in cycle N+1 at earliest, if its ready bit is set.
- Fire in cycle N → `issue_valid_o` = 1 and payload visible in cycle N+1.
- Throughput: one issue per cycle while `issue_ready_i` = 1 and the head is ready.
- `issue_addr_o` and `clear_busy_o` depend only on registered state, `ready_vector_i`, `issue_ready_i` and `flush_i`; the payload inputs are sampled only at fire.
- Reset mid-stream: the queue and output stage are discarded at the next edge, with no fire during reset.

## Configuration

- `LDST_ISSUE_PERF_EN` defined:
  - adds outputs `perf_issued_o` (32-bit count of fires) and `perf_stall_o` (32-bit count of cycles with count ≠ 0 and no fire);
  - both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent.

## Test plan

- Reset, then push entry 2 (slot 1) and entry 0 (slot 2) in one cycle, all ready → fires with `issue_addr_o` 2 then 0 on consecutive cycles; `issue_valid_o` high 2 cycles carrying entry 2 then entry 0 payloads.
- Push 1 then 3; only `ready_vector_i` = 4'b1000 → no fire, `perf_stall_o` increments; set bit 1 → fire on entry 1, then entry 3 next cycle.
- Output held with `issue_ready_i` = 0 and head ready → `clear_busy_o` = 0 and the payload is stable; raise `issue_ready_i` → fire the same cycle.
- Fill 4 entries, then in one cycle fire and push one → count stays 4 and `overflow_o` stays 0; a push of 2 at count 4 with no fire → `overflow_o` = 1 and count stays 4.
- Flush with 3 queued and `issue_valid_o` = 1 → `clear_busy_o` = 0 in the flush cycle; next cycle count = 0 and `issue_valid_o` = 0.
- Wrap-around: push and issue 10 entries in rotating order 0..3 → issue order matches push order across pointer wrap.
